axi_master_fsm: RTL and testbench

//  Single-outstanding AXI-lite-style master; feeds the slave FSM directly downstream on the same bus.

---
 rtl/axi_bus_pkg.sv | 29 ++
 rtl/axi_watchdog.sv | 46 ++++
 rtl/axi_master_fsm.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_master_fsm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bus_pkg.sv
// Shared definitions for the AXI-lite style master/slave pair: state encoding,
// response codes, lane count and the byte-lane masking helper.
package axi_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } axi_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int unsigned NUM_LANES  = 4;

    // Zero every byte lane whose enable bit is low.
    function automatic logic [31:0] lane_mask(input logic [31:0] data,
                                              input logic [NUM_LANES-1:0] lanes);
        logic [31:0] masked;
        masked = 32'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            masked[i*8 +: 8] = lanes[i] ? data[i*8 +: 8] : 8'd0;
        end
        return masked;
    endfunction

endpackage

// File: rtl/axi_watchdog.sv
// Handshake watchdog: counts cycles while enabled, restarts on clear and
// flags expiry once the count reaches TIMEOUT_CYC-1. The count saturates.
module axi_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             expired_q;
    logic             expired_d;

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        expired_d = (cnt_d == LAST);
    end

    // Counter and registered expiry flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/axi_master_fsm.sv
// Single-outstanding AXI-lite style master. Turns one user command into an
// AW/W/B or AR/R exchange, returns data/status, and aborts stuck handshakes.
module axi_master_fsm
    import axi_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              M_ACLK,
    input  logic              M_ARRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              M_AWVALID,
    output logic [ADDR_W-1:0] M_AWADDR,
    input  logic              S_AWREADY,
    output logic              M_WVALID,
    output logic [DATA_W-1:0] M_WDATA,
    output logic [3:0]        M_WSTRB,
    input  logic              S_WREADY,
    input  logic              S_BVALID,
    input  logic [1:0]        S_BRESP,
    output logic              M_BREADY,
    output logic              M_ARVALID,
    output logic [ADDR_W-1:0] M_ARADDR,
    input  logic              S_ARREADY,
    input  logic              S_RVALID,
    input  logic [DATA_W-1:0] S_RDATA,
    output logic              M_RREADY,
    output logic [3:0]        M_BLEN
);

    axi_state_e        state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              aw_valid_q,  aw_valid_d;
    logic              w_valid_q,   w_valid_d;
    logic              b_ready_q,   b_ready_d;
    logic              ar_valid_q,  ar_valid_d;
    logic              r_ready_q,   r_ready_d;
    logic              aw_done_q,   aw_done_d;
    logic              w_done_q,    w_done_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [3:0]        strb_q,      strb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic aw_hs_s;
    logic w_hs_s;
    logic abort_s;
    logic bus_state_s;
    logic wd_clear_s;
    logic wd_expired_s;

    assign aw_hs_s     = aw_valid_q & S_AWREADY;
    assign w_hs_s      = w_valid_q & S_WREADY;
    assign bus_state_s = (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP) ||
                         (state_q == ST_RD_REQ)  || (state_q == ST_RD_DATA);
    // Restart the count on every state change so each bus state gets a full budget.
    assign wd_clear_s  = (state_d != state_q) || !bus_state_s;

    axi_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (M_ACLK),
        .rst     (M_ARRESET),
        .clear   (wd_clear_s),
        .enable  (bus_state_s),
        .expired (wd_expired_s)
    );

    // Next-state and next-output decode; a completed handshake beats a timeout.
    always_comb begin
        state_d     = state_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready_d = 1'b0;
        abort_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    strb_d      = cmd_strb;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    if (cmd_write) begin
                        state_d    = ST_WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = ST_RD_REQ;
                        ar_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; each VALID drops after its own handshake.
                aw_done_d  = aw_done_q | aw_hs_s;
                w_done_d   = w_done_q | w_hs_s;
                aw_valid_d = aw_valid_q & ~aw_hs_s;
                w_valid_d  = w_valid_q & ~w_hs_s;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WR_RESP;
                    b_ready_d = 1'b1;
                end else begin
                    abort_s = wd_expired_s;
                end
            end
            ST_WR_RESP: begin
                if (S_BVALID && b_ready_q) begin
                    b_ready_d   = 1'b0;
                    rsp_err_d   = (S_BRESP != RESP_OKAY);
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    abort_s = wd_expired_s;
                end
            end
            ST_RD_REQ: begin
                // Any RVALID seen here is ignored; data is only taken in RD_DATA.
                if (ar_valid_q && S_ARREADY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end else begin
                    abort_s = wd_expired_s;
                end
            end
            ST_RD_DATA: begin
                if (S_RVALID && r_ready_q) begin
                    r_ready_d   = 1'b0;
                    rsp_rdata_d = lane_mask(S_RDATA, strb_q);
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    abort_s = wd_expired_s;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        if (abort_s) begin
            aw_valid_d  = 1'b0;
            w_valid_d   = 1'b0;
            b_ready_d   = 1'b0;
            ar_valid_d  = 1'b0;
            r_ready_d   = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
            cmd_ready_d = 1'b0;
        end else begin
            cmd_ready_d = (state_d == ST_IDLE);
        end
    end

    // FSM state, captured command fields and all registered outputs.
    always_ff @(posedge M_ACLK or posedge M_ARRESET) begin
        if (M_ARRESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign M_AWVALID = aw_valid_q;
    assign M_AWADDR  = addr_q;
    assign M_WVALID  = w_valid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = strb_q;
    assign M_BREADY  = b_ready_q;
    assign M_ARVALID = ar_valid_q;
    assign M_ARADDR  = addr_q;
    assign M_RREADY  = r_ready_q;
    assign M_BLEN    = strb_q;

endmodule

// File: tb/tb_axi_master_fsm.sv
// Scoreboard bench for axi_master_fsm: a configurable slave model answers the
// bus, expected responses are queued at command acceptance and a monitor
// compares them when the DUT hands a response over.
module tb_axi_master_fsm;
    import axi_bus_pkg::*;

    localparam int TO = 8;

    logic        M_ACLK = 1'b0;
    logic        M_ARRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        M_AWVALID, S_AWREADY, M_WVALID, S_WREADY;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, S_RDATA;
    logic [3:0]  M_WSTRB, M_BLEN;
    logic        S_BVALID, M_BREADY, M_ARVALID, S_ARREADY, S_RVALID, M_RREADY;
    logic [1:0]  S_BRESP;

    axi_master_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .M_ACLK(M_ACLK), .M_ARRESET(M_ARRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
        .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
        .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .M_BREADY(M_BREADY),
        .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .S_ARREADY(S_ARREADY),
        .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .M_RREADY(M_RREADY), .M_BLEN(M_BLEN)
    );

    always #5 M_ACLK = ~M_ACLK;

    logic [143:0] all_outs;
    assign all_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, M_AWVALID, M_AWADDR,
                       M_WVALID, M_WDATA, M_WSTRB, M_BREADY, M_ARVALID, M_ARADDR,
                       M_RREADY, M_BLEN};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge M_ACLK) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q[$];
    int   rsp_seen = 0;
    int   first_cyc = 0;
    int   accept_cyc = 0;

    // slave configuration for the current transaction
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          aw_nv, w_nv, b_nv, ar_nv, r_nv;
    logic [1:0]  bresp_cfg;
    logic [31:0] rdata_cfg, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    int          stray_mode = 0;
    int          rr_mode = 0;
    int          aw_hs_n, w_hs_n, ar_hs_n;
    int          last_b_run = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Slave model: per-channel READY/VALID after configured delays, optional stray VALIDs.
    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_run;
        bit aw_p, w_p, ar_p, real_r, real_b, stray_r, stray_b;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_run = 0;
        aw_p = 0; w_p = 0; ar_p = 0;
        S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_BRESP = 2'b00;
        S_ARREADY = 0; S_RVALID = 0; S_RDATA = 32'd0;
        forever begin
            @(posedge M_ACLK); #1;
            if (M_ARRESET) begin
                S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_ARREADY = 0; S_RVALID = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_run = 0;
                aw_p = 0; w_p = 0; ar_p = 0;
            end else begin
                if (aw_p) check("aw_drop", M_AWVALID, 1'b0);
                if (w_p)  check("w_drop", M_WVALID, 1'b0);
                if (ar_p) check("ar_drop", M_ARVALID, 1'b0);
                if (aw_p && (w_hs_n == 0) && !w_nv) check("w_held", M_WVALID, 1'b1);
                S_AWREADY = M_AWVALID && !aw_nv && (aw_cnt >= aw_dly);
                aw_cnt    = M_AWVALID ? aw_cnt + 1 : 0;
                S_WREADY  = M_WVALID && !w_nv && (w_cnt >= w_dly);
                w_cnt     = M_WVALID ? w_cnt + 1 : 0;
                S_ARREADY = M_ARVALID && !ar_nv && (ar_cnt >= ar_dly);
                ar_cnt    = M_ARVALID ? ar_cnt + 1 : 0;
                real_b  = M_BREADY && !b_nv && (b_cnt >= b_dly);
                stray_b = !M_BREADY && (stray_mode == 2 || (stray_mode == 1 && $urandom_range(3) == 0));
                S_BVALID = real_b || stray_b;
                S_BRESP  = real_b ? bresp_cfg : ~bresp_cfg;
                b_cnt    = M_BREADY ? b_cnt + 1 : 0;
                if (M_BREADY) b_run++;
                else if (b_run != 0) begin last_b_run = b_run; b_run = 0; end
                real_r  = M_RREADY && !r_nv && (r_cnt >= r_dly);
                stray_r = !M_RREADY && (stray_mode == 2 || (stray_mode == 1 && $urandom_range(3) == 0));
                S_RVALID = real_r || stray_r;
                S_RDATA  = real_r ? rdata_cfg : ~rdata_cfg;
                r_cnt    = M_RREADY ? r_cnt + 1 : 0;
                aw_p = M_AWVALID && S_AWREADY;
                w_p  = M_WVALID && S_WREADY;
                ar_p = M_ARVALID && S_ARREADY;
                if (aw_p) begin aw_hs_n++; check("awaddr", M_AWADDR, exp_addr); end
                if (w_p) begin
                    w_hs_n++;
                    check("wdata", M_WDATA, exp_wdata);
                    check("wstrb", M_WSTRB, exp_strb);
                end
                if (ar_p) begin
                    ar_hs_n++;
                    check("araddr", M_ARADDR, exp_addr);
                    check("blen", M_BLEN, exp_strb);
                end
            end
        end
    end

    // Response consumer readiness: 0 = always ready, 1 = random, 2 = held low.
    initial begin : rsp_drv
        rsp_ready = 1'b0;
        forever begin
            @(posedge M_ACLK); #1;
            case (rr_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare an expected response on every response handshake.
    initial begin : monitor
        exp_t e;
        bit   prev_v;
        prev_v = 0;
        forever begin
            @(negedge M_ACLK);
            if (M_ARRESET) begin
                prev_v = 0;
            end else begin
                if (rsp_valid && !prev_v) first_cyc = cyc;
                prev_v = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", rsp_err, e.err);
                    end
                    rsp_seen++;
                end
            end
        end
    end

    task automatic cfg_clear();
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        aw_nv = 0; w_nv = 0; b_nv = 0; ar_nv = 0; r_nv = 0;
        bresp_cfg = RESP_OKAY; rdata_cfg = 32'd0; stray_mode = 0; rr_mode = 0;
    endtask

    // Issue one command; queue the expected response computed from the protocol rules.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit expect_rsp);
        exp_t e;
        int   waited;
        exp_addr = addr; exp_wdata = wdata; exp_strb = strb;
        if (wr) begin
            e.rdata = 32'd0;
            e.err   = (aw_nv || w_nv || b_nv) ? 1'b1 : (bresp_cfg != RESP_OKAY);
        end else begin
            e.err   = ar_nv || r_nv;
            e.rdata = e.err ? 32'd0 :
                      rdata_cfg & {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        end
        aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0;
        @(posedge M_ACLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        waited = 0;
        @(negedge M_ACLK);
        while (!cmd_ready && waited < 50) begin @(negedge M_ACLK); waited++; end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge M_ACLK); #1;
        accept_cyc = cyc - 1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom_range(1));
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = 4'($urandom_range(15));
        if (expect_rsp) exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input int target);
        int waited;
        waited = 0;
        while (rsp_seen < target && waited < 100) begin @(negedge M_ACLK); waited++; end
        check("rsp_arrived", rsp_seen >= target, 1'b1);
    endtask

    task automatic check_hs(input bit wr);
        if (wr) begin
            check("aw_hs_count", aw_hs_n, 1);
            check("w_hs_count", w_hs_n, 1);
        end else begin
            check("ar_hs_count", ar_hs_n, 1);
        end
    endtask

    initial begin : global_timeout
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int tgt, waited, k, s, vcnt;
        bit wr;
        cfg_clear();
        M_ARRESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        repeat (3) @(negedge M_ACLK);
        check("reset_outputs", all_outs, 144'd0);
        M_ARRESET = 1'b0;

        // write 0x04 <- 0xA1B2C3D4, ready slave, minimum latency
        cfg_clear();
        tgt = rsp_seen + 1; issue(1, 32'h4, 32'hA1B2C3D4, 4'hF, 1); wait_rsp(tgt);
        check("wr_latency", first_cyc - accept_cyc, 3);
        check_hs(1);

        // read 0x04 with lanes 4'h3
        cfg_clear(); rdata_cfg = 32'hA1B2C3D4;
        tgt = rsp_seen + 1; issue(0, 32'h4, 32'h0, 4'h3, 1); wait_rsp(tgt);
        check("rd_latency", first_cyc - accept_cyc, 3);
        check_hs(0);

        // AW accepted three cycles before W
        cfg_clear(); w_dly = 3;
        tgt = rsp_seen + 1; issue(1, 32'h100, 32'h12345678, 4'h5, 1); wait_rsp(tgt);
        check_hs(1);

        // slave never answers B: abort after TO cycles in WR_RESP
        cfg_clear(); b_nv = 1;
        tgt = rsp_seen + 1; issue(1, 32'h8, 32'hDEADBEEF, 4'hF, 1); wait_rsp(tgt);
        check("bready_cycles", last_b_run, TO);
        check("bready_dropped", M_BREADY, 1'b0);

        // SLVERR response held by a stalled consumer
        cfg_clear(); bresp_cfg = RESP_SLVERR; rr_mode = 2;
        tgt = rsp_seen + 1; issue(1, 32'hC, 32'h0BADF00D, 4'hA, 1);
        waited = 0;
        while (!rsp_valid && waited < 30) begin @(negedge M_ACLK); waited++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge M_ACLK);
            check("rsp_hold", {rsp_valid, rsp_err, cmd_ready}, 3'b110);
        end
        rr_mode = 0;
        wait_rsp(tgt);

        // stray RVALID during RD_REQ (coincides with ARREADY) must be ignored
        cfg_clear(); stray_mode = 2; ar_dly = 1; r_dly = 2; rdata_cfg = 32'h55AA33CC;
        tgt = rsp_seen + 1; issue(0, 32'h40, 32'h0, 4'hC, 1); wait_rsp(tgt);
        check_hs(0);

        // reset while waiting in RD_DATA: silent drop, then a clean read
        cfg_clear(); r_nv = 1;
        issue(0, 32'h80, 32'h0, 4'hF, 0);
        waited = 0;
        while (!M_RREADY && waited < 20) begin @(negedge M_ACLK); waited++; end
        check("reached_rd_data", M_RREADY, 1'b1);
        M_ARRESET = 1'b1; #1;
        check("async_reset_outputs", all_outs, 144'd0);
        @(negedge M_ACLK); M_ARRESET = 1'b0; r_nv = 0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin @(negedge M_ACLK); if (rsp_valid) vcnt++; end
        check("no_rsp_after_reset", vcnt, 0);
        check("idle_after_reset", cmd_ready, 1'b1);
        rdata_cfg = 32'hCAFEF00D;
        tgt = rsp_seen + 1; issue(0, 32'h84, 32'h0, 4'h9, 1); wait_rsp(tgt);
        check_hs(0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            cfg_clear();
            wr = 1'($urandom_range(1));
            aw_dly = $urandom_range(3); w_dly = $urandom_range(3); b_dly = $urandom_range(3);
            ar_dly = $urandom_range(3); r_dly = $urandom_range(3);
            bresp_cfg = 2'($urandom_range(3)); rdata_cfg = $urandom;
            stray_mode = $urandom_range(1); rr_mode = $urandom_range(1);
            k = $urandom_range(9);
            if (k == 0) begin
                if (wr) begin
                    s = $urandom_range(2); aw_nv = (s == 0); w_nv = (s == 1); b_nv = (s == 2);
                end else begin
                    s = $urandom_range(1); ar_nv = (s == 0); r_nv = (s == 1);
                end
            end
            tgt = rsp_seen + 1;
            issue(wr, $urandom, $urandom, 4'($urandom_range(15)), 1);
            wait_rsp(tgt);
            if (!(aw_nv || w_nv || b_nv || ar_nv || r_nv)) check_hs(wr);
        end

        rr_mode = 0;
        repeat (3) @(negedge M_ACLK);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
